mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back datapath for the 5-stage RV32I core.
- Registers the MEM-stage result bundle, including the wb_sel/rd_wren pair produced by the write-back control decoder.
- Performs load-data alignment and sign/zero extension, then selects the final register-file write data.
- Drives the register-file write port and the WB forwarding path.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- INSTRET_W, 64, width of the retire counter; used only when WB_INSTRET_EN is defined.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  reset.
- stall  input  1  hold the WB register contents.
- flush  input  1  load a bubble into the WB register.
- mem_valid  input  1  MEM stage holds a real instruction.
- mem_pc  input  XLEN  PC of the MEM instruction.
- mem_alu_data  input  XLEN  ALU result; also the load address.
- mem_ld_raw  input  XLEN  aligned 32-bit word returned by the LSU.
- mem_funct3  input  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_rd_addr  input  5  destination register.
- mem_wb_sel  input  2  write-back select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
- mem_rd_wren  input  1  destination write enable.
- wb_valid  output  1  WB holds a real instruction.
- wb_pc  output  XLEN  PC of the WB instruction.
- wb_rd_addr  output  5  register-file write address.
- wb_rd_data  output  XLEN  register-file write data.
- wb_rd_wren  output  1  register-file write enable.
- wb_instret  output  INSTRET_W  retired-instruction count; present only with WB_INSTRET_EN.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- While rst=1, all WB registers clear immediately, without waiting for a clock edge:
  - wb_valid=0, wb_pc=0, wb_rd_addr=0, wb_rd_wren=0.
  - Internal alu/ld/funct3/wb_sel registers = 0, so wb_rd_data=0.
- Register update, per rising clk edge, in priority order:
  - flush=1: load a bubble (valid=0, rd_wren=0, rd_addr=0, other fields 0). Flush overrides stall.
  - else stall=1: hold all registers unchanged.
  - else: capture all mem_* inputs.
- Captured write enable: wren_q = mem_rd_wren & mem_valid & (mem_rd_addr != 0).
  - x0 is never written.
  - An invalid instruction never writes.
- Latency:
  - MEM inputs appear on the wb_* outputs exactly 1 cycle after capture.
  - wb_rd_data is combinational from the registered fields; there is no second register stage.
- Load extraction, using off = alu_q[1:0]:
  - LB/LBU: byte = ld_q[8*off+7 : 8*off]; sign-extend from bit 7 (LB) or zero-extend (LBU).
  - LH/LHU: half = off[1] ? ld_q[31:16] : ld_q[15:0]; off[0] is ignored (no misaligned trap here); sign- or zero-extend.
  - LW and any other funct3: ld_q passed through unchanged.
- Write-data mux, by registered wb_sel:
  - 00: alu_q.
  - 01: extended load data.
  - 10: pc_q + 4, modulo 2^32; 0xFFFFFFFC gives 0x00000000.
  - 11: 0.
- wb_rd_data is driven even when wb_rd_wren=0; consumers must qualify it with wb_rd_wren.
- Stall followed by flush: the held instruction is discarded and never asserts wren again.
- Reset during a stall discards the held instruction.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - wb_instret is an INSTRET_W-bit counter; reset value 0.
  - Increments by 1 on each rising edge where wb_valid=1 and stall=0, so each retired instruction counts exactly once even if it is held.
  - Wraps to 0 after all-ones.
  - Bubbles do not count.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with a valid write pending -> all outputs are 0 immediately; after rst=0 and one idle edge, wb_rd_wren stays 0.
- ALU write: mem_valid=1, wb_sel=00, alu=0x12345678, rd=5, wren=1 -> next cycle wb_rd_addr=5, wb_rd_data=0x12345678, wb_rd_wren=1.
- x0 write: same as the ALU write but rd=0 -> wb_rd_wren=0.
- Loads: ld_raw=0x80F17F01 with each load type/offset -> required wb_rd_data:
  - LB, off=3: 0xFFFFFF80.
  - LBU, off=3: 0x00000080.
  - LH, off=2: 0xFFFF80F1.
  - LHU, off=0: 0x00007F01.
  - LW: 0x80F17F01.
- JAL write: wb_sel=10, pc=0x00000100 -> wb_rd_data=0x00000104.
- JAL wrap: wb_sel=10, pc=0xFFFFFFFC -> wb_rd_data=0x00000000.
- Stall/flush: capture an instruction, hold stall=1 for 3 cycles -> outputs are stable; then flush=1 with stall=1 -> next cycle wb_valid=0, wb_rd_wren=0.
- Counter (with WB_INSTRET_EN): 4 valid instructions, 2 bubbles and one 3-cycle stall -> wb_instret=4.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment/extension and write-back data select.
// Optional retire counter on wb_instret when WB_INSTRET_EN is defined.
module mem_wb_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic [XLEN-1:0]      mem_pc,
  input  logic [XLEN-1:0]      mem_alu_data,
  input  logic [XLEN-1:0]      mem_ld_raw,
  input  logic [2:0]           mem_funct3,
  input  logic [4:0]           mem_rd_addr,
  input  logic [1:0]           mem_wb_sel,
  input  logic                 mem_rd_wren,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      wb_pc,
  output logic [4:0]           wb_rd_addr,
  output logic [XLEN-1:0]      wb_rd_data,
  output logic                 wb_rd_wren
`ifdef WB_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] wb_instret
`endif
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_ld;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd_addr;
  logic [1:0]      r_wb_sel;
  logic            r_wren;

  // Flush wins over stall so a held instruction can be discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_alu     <= '0;
      r_ld      <= '0;
      r_funct3  <= '0;
      r_rd_addr <= '0;
      r_wb_sel  <= '0;
      r_wren    <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_alu     <= '0;
      r_ld      <= '0;
      r_funct3  <= '0;
      r_rd_addr <= '0;
      r_wb_sel  <= '0;
      r_wren    <= 1'b0;
    end else if (!stall) begin
      r_valid   <= mem_valid;
      r_pc      <= mem_pc;
      r_alu     <= mem_alu_data;
      r_ld      <= mem_ld_raw;
      r_funct3  <= mem_funct3;
      r_rd_addr <= mem_rd_addr;
      r_wb_sel  <= mem_wb_sel;
      r_wren    <= mem_rd_wren & mem_valid & (mem_rd_addr != 5'd0);
    end
  end

  logic [XLEN-1:0] w_ld_shift;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ld_ext;

  always_comb begin
    w_ld_shift = r_ld >> {r_alu[1:0], 3'b000};
    w_byte     = w_ld_shift[7:0];
    // Halfword offset bit 0 is ignored; misalignment is trapped elsewhere.
    w_half     = r_alu[1] ? r_ld[31:16] : r_ld[15:0];
    case (r_funct3)
      3'b000:  w_ld_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_ld_ext = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_ld_ext = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_ld_ext = {{(XLEN-16){1'b0}}, w_half};
      default: w_ld_ext = r_ld;
    endcase
  end

  always_comb begin
    case (r_wb_sel)
      2'b00:   wb_rd_data = r_alu;
      2'b01:   wb_rd_data = w_ld_ext;
      2'b10:   wb_rd_data = r_pc + XLEN'(4);
      default: wb_rd_data = '0;
    endcase
  end

  assign wb_valid   = r_valid;
  assign wb_pc      = r_pc;
  assign wb_rd_addr = r_rd_addr;
  assign wb_rd_wren = r_wren;

`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] r_instret;

  // Counts on departure from WB, so a held instruction is counted once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
    end else if (r_valid && !stall) begin
      r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  assign wb_instret = r_instret;
`endif

endmodule
